// File: rtl/shift_seq_pkg.sv
// Shared constants and state encoding for the multi-cycle shift sequencer.
package shift_seq_pkg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/shift_sequencer_shifter.sv
// Single-step 16-bit shifter: one bit of LSL, LSR or ASR per use.
module shift_sequencer_shifter
    import shift_seq_pkg::*;
(
    input  logic [DATA_W-1:0] in_i,
    input  logic [1:0]        shift_i,
    output logic [DATA_W-1:0] out_o
);

    always_comb begin
        out_o = in_i;
        case (shift_i)
            SH_LSL:  out_o = {in_i[DATA_W-2:0], 1'b0};
            SH_LSR:  out_o = {1'b0, in_i[DATA_W-1:1]};
            SH_ASR:  out_o = {in_i[DATA_W-1], in_i[DATA_W-1:1]};
            default: out_o = in_i;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Sequences the single-step shifter to perform shift-by-N (N = 0..15)
// with a start/ready handshake and a one-cycle done pulse.
module shift_sequencer
    import shift_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        op,
    input  logic [CNT_W-1:0]  amount,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic [DATA_W-1:0] sh_out;

    shift_sequencer_shifter u_shifter (
        .in_i    (acc_q),
        .shift_i (op_q),
        .out_o   (sh_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            op_q     <= SH_NONE;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = in_data;
                    op_d  = op;
                    cnt_d = amount;
                    if (amount == '0) begin
                        result_d = in_data;
                        state_d  = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // cnt == 0 cannot occur here; bail out rather than wrap
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    acc_d = sh_out;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        result_d = sh_out;
                        state_d  = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ready  = (state_q == IDLE);
    assign busy   = (state_q == RUN) || (state_q == DONE);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: vector table plus corner sequences.
module tb_shift_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] in_data;
    logic [1:0]  op;
    logic [3:0]  amount;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] result;

    int cmp_cnt = 0;
    int bad_cnt = 0;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  op;
        logic [3:0]  amt;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[11];

    shift_sequencer dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .in_data (in_data),
        .op      (op),
        .amount  (amount),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue at a negedge, accept on the following posedge (E0), return at
    // the negedge after E0 with start dropped.
    task automatic issue(input logic [15:0] d, input logic [1:0] o,
                         input logic [3:0] a);
        in_data = d;
        op      = o;
        amount  = a;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges after E0 until done is seen; called at negedge after E0.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            bad_cnt++;
            cmp_cnt++;
            $display("FAIL done_timeout: got no done expected done");
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        issue(v.data, v.op, v.amt);
        chk({tag, "_ready_low"}, {31'b0, ready}, 32'd0);
        chk({tag, "_busy_high"}, {31'b0, busy}, 32'd1);
        wait_done(lat);
        chk({tag, "_latency"}, lat, {28'b0, v.amt});
        chk({tag, "_result"}, {16'b0, result}, {16'b0, v.exp});
        @(negedge clk);
        chk({tag, "_ready_after"}, {31'b0, ready}, 32'd1);
        chk({tag, "_done_one"}, {31'b0, done}, 32'd0);
        chk({tag, "_result_hold"}, {16'b0, result}, {16'b0, v.exp});
    endtask

    initial begin
        int lat;
        int dc;
        vecs[0]  = '{16'h0001, 2'b01, 4'd4,  16'h0010};
        vecs[1]  = '{16'h8000, 2'b11, 4'd15, 16'hFFFF};
        vecs[2]  = '{16'h8000, 2'b10, 4'd15, 16'h0001};
        vecs[3]  = '{16'hBEEF, 2'b01, 4'd0,  16'hBEEF};
        vecs[4]  = '{16'hBEEF, 2'b00, 4'd7,  16'hBEEF};
        vecs[5]  = '{16'h00F0, 2'b10, 4'd3,  16'h001E};
        vecs[6]  = '{16'h1234, 2'b01, 4'd8,  16'h3400};
        vecs[7]  = '{16'h0F00, 2'b11, 4'd4,  16'h00F0};
        vecs[8]  = '{16'hA5A5, 2'b11, 4'd1,  16'hD2D2};
        vecs[9]  = '{16'h8001, 2'b01, 4'd1,  16'h0002};
        vecs[10] = '{16'h00F0, 2'b11, 4'd0,  16'h00F0};

        reset   = 1'b1;
        start   = 1'b0;
        in_data = '0;
        op      = '0;
        amount  = '0;
        @(negedge clk);
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", {16'b0, result}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Back-to-back: next request issued the cycle ready returns
        for (int i = 0; i < 11; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Request during RUN must be ignored
        issue(16'h00F0, 2'b10, 4'd3);
        in_data = 16'hFFFF;
        amount  = 4'd1;
        op      = 2'b01;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dc = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) dc++;
            if (done)
                chk("busy_prot_result", {16'b0, result}, 32'h001E);
            @(negedge clk);
        end
        chk("busy_prot_pulses", dc, 32'd1);
        chk("busy_prot_hold", {16'b0, result}, 32'h001E);

        // Async reset between edges mid-RUN
        issue(16'h1234, 2'b01, 4'd10);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_ready", {31'b0, ready}, 32'd1);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_done", {31'b0, done}, 32'd0);
        chk("arst_result", {16'b0, result}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        dc = 0;
        for (int i = 0; i < 15; i++) begin
            if (done || busy) dc++;
            @(negedge clk);
        end
        chk("arst_no_stale", dc, 32'd0);
        run_vec('{16'h0003, 2'b01, 4'd2, 16'h000C}, "post_rst");

        // Result held for 20 idle cycles
        dc = 0;
        for (int i = 0; i < 20; i++) begin
            if (result !== 16'h000C || !ready) dc++;
            @(negedge clk);
        end
        chk("long_hold", dc, 32'd0);
        issue(16'h0100, 2'b10, 4'd0);
        wait_done(lat);
        chk("hold_new_lat", lat, 32'd0);
        chk("hold_new_result", {16'b0, result}, 32'h0100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 cmp_cnt, bad_cnt);
        $finish;
    end

endmodule
